// File: rtl/booth4_mul_arbiter_if.sv
// Handshake bundle for the shared Booth multiplier: per-requester operand channels
// in, one tagged result channel out.
interface booth4_mul_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_mcand;
   logic [NREQ*WIDTH-1:0] req_mplier;
   logic                  res_valid;
   logic                  res_ready;
   logic [IDW-1:0]        res_id;
   logic [2*WIDTH-1:0]    res_product;
   logic                  busy;

   modport slave (
      input  req_valid, req_mcand, req_mplier, res_ready,
      output req_ready, res_valid, res_id, res_product, busy
   );

   modport master (
      output req_valid, req_mcand, req_mplier, res_ready,
      input  req_ready, res_valid, res_id, res_product, busy
   );
endinterface

// File: rtl/booth4_mul_arbiter.sv
// Round-robin shared radix-4 Booth multiplier: one granted requester at a time,
// one partial product retired per clock, product returned tagged with the owner id.
module booth4_mul_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   booth4_mul_arbiter_if.slave bus
);
   localparam int IDW   = $clog2(NREQ);
   localparam int NSTEP = WIDTH / 2;
   localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [SW-1:0]  LAST_STEP = SW'(NSTEP - 1);
   localparam logic [IDW-1:0] LAST_REQ  = IDW'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e               state_q;
   logic [IDW-1:0]       rr_ptr_q;
   logic [IDW-1:0]       id_q;
   logic [2*WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]     q_q;
   logic                 q_m1_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [SW-1:0]        step_q;
   logic                 res_valid_q;
   logic [IDW-1:0]       res_id_q;
   logic [2*WIDTH-1:0]   res_product_q;

   logic                 grant_found;
   logic [IDW-1:0]       grant_id;
   logic [IDW-1:0]       scan_idx;
   logic [NREQ-1:0]      req_ready_d;
   logic [WIDTH-1:0]     mcand_sel;
   logic [WIDTH-1:0]     mplier_sel;
   logic [2*WIDTH-1:0]   pp_d;
   logic [2*WIDTH-1:0]   acc_d;

   // Round-robin search starting at rr_ptr_q and wrapping.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
         if (!grant_found && bus.req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_id    = scan_idx;
         end
      end
   end

   always_comb begin
      req_ready_d = '0;
      mcand_sel   = '0;
      mplier_sel  = '0;
      if (state_q == IDLE && grant_found) begin
         req_ready_d[grant_id] = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == grant_id) begin
            mcand_sel  = bus.req_mcand[i*WIDTH +: WIDTH];
            mplier_sel = bus.req_mplier[i*WIDTH +: WIDTH];
         end
      end
   end

   // m_q is pre-shifted by 2k, so the selected multiple is already aligned to acc.
   always_comb begin
      pp_d = '0;
      case ({q_q[1:0], q_m1_q})
         3'b001, 3'b010: pp_d = m_q;
         3'b011:         pp_d = m_q << 1;
         3'b100:         pp_d = -(m_q << 1);
         3'b101, 3'b110: pp_d = -m_q;
         default:        pp_d = '0;
      endcase
      acc_d = acc_q + pp_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         id_q          <= '0;
         m_q           <= '0;
         q_q           <= '0;
         q_m1_q        <= 1'b0;
         acc_q         <= '0;
         step_q        <= '0;
         res_valid_q   <= 1'b0;
         res_id_q      <= '0;
         res_product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_found) begin
                  m_q      <= {{WIDTH{mcand_sel[WIDTH-1]}}, mcand_sel};
                  q_q      <= mplier_sel;
                  q_m1_q   <= 1'b0;
                  acc_q    <= '0;
                  step_q   <= '0;
                  id_q     <= grant_id;
                  rr_ptr_q <= (grant_id == LAST_REQ) ? '0 : grant_id + 1'b1;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               acc_q  <= acc_d;
               m_q    <= m_q << 2;
               q_q    <= q_q >> 2;
               q_m1_q <= q_q[1];
               step_q <= step_q + 1'b1;
               if (step_q == LAST_STEP) begin
                  res_product_q <= acc_d;
                  res_id_q      <= id_q;
                  res_valid_q   <= 1'b1;
                  state_q       <= DONE;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = req_ready_d;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_id      = res_id_q;
   assign bus.res_product = res_product_q;
   assign bus.busy        = (state_q != IDLE);

endmodule
